// File: rtl/sram_ctrl.sv
// Wishbone-style slave for an asynchronous 16-bit SRAM: registered pins,
// programmable read wait states and a setup / pulse / hold write cycle.
module sram_ctrl #(
  parameter int unsigned WAIT_RD = 2,
  parameter int unsigned WAIT_WR = 2
) (
  input  logic        clk_50mhz,
  input  logic        i_reset,
  input  logic [15:0] i_wb_addr,
  input  logic [15:0] i_wb_dat,
  input  logic [1:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [15:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic [15:0] sram_addr,
  inout  wire  [15:0] sram_data,
  output logic        sram_cen,
  output logic        sram_oen,
  output logic        sram_wen,
  output logic        sram_ubn,
  output logic        sram_lbn
);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_DONE,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD
  } state_t;

  localparam logic [3:0] RD_CNT = 4'(WAIT_RD);
  localparam logic [3:0] WR_CNT = 4'(WAIT_WR);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdat_q, wdat_d;
  logic [15:0] rdat_q, rdat_d;
  logic        ack_q, ack_d;
  logic        drive_q, drive_d;
  logic        cen_q, cen_d;
  logic        oen_q, oen_d;
  logic        wen_q, wen_d;
  logic        ubn_q, ubn_d;
  logic        lbn_q, lbn_d;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned and infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    drive_d = drive_q;
    cen_d   = cen_q;
    oen_d   = oen_q;
    wen_d   = wen_q;
    ubn_d   = ubn_q;
    lbn_d   = lbn_q;

    unique case (state_q)
      IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          addr_d = i_wb_addr;
          wdat_d = i_wb_dat;
          cen_d  = 1'b0;
          if (i_wb_we) begin
            state_d = WR_SETUP;
            cnt_d   = WR_CNT;
            ubn_d   = ~i_wb_sel[1];
            lbn_d   = ~i_wb_sel[0];
            drive_d = 1'b1;
          end else begin
            state_d = RD;
            cnt_d   = RD_CNT;
            oen_d   = 1'b0;
            ubn_d   = 1'b0;
            lbn_d   = 1'b0;
          end
        end
      end

      RD: begin
        cnt_d = cnt_q - 4'd1;
        // Counter hits zero on this edge: sample the bus while oen is still low.
        if (cnt_q == 4'd1) begin
          rdat_d  = sram_data;
          ack_d   = 1'b1;
          cen_d   = 1'b1;
          oen_d   = 1'b1;
          ubn_d   = 1'b1;
          lbn_d   = 1'b1;
          state_d = RD_DONE;
        end
      end

      RD_DONE: state_d = IDLE;

      WR_SETUP: begin
        wen_d   = 1'b0;
        state_d = WR_PULSE;
      end

      WR_PULSE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          wen_d   = 1'b1;
          ack_d   = 1'b1;
          state_d = WR_HOLD;
        end
      end

      WR_HOLD: begin
        cen_d   = 1'b1;
        ubn_d   = 1'b1;
        lbn_d   = 1'b1;
        drive_d = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50mhz) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge values, independent of statement order.
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      drive_q <= 1'b0;
      cen_q   <= 1'b1;
      oen_q   <= 1'b1;
      wen_q   <= 1'b1;
      ubn_q   <= 1'b1;
      lbn_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      drive_q <= drive_d;
      cen_q   <= cen_d;
      oen_q   <= oen_d;
      wen_q   <= wen_d;
      ubn_q   <= ubn_d;
      lbn_q   <= lbn_d;
    end
  end

  // A master that abandons its cycle never sees the late acknowledge.
  assign o_wb_ack  = ack_q & i_wb_cyc;
  assign o_wb_dat  = rdat_q;
  assign sram_addr = addr_q;
  assign sram_cen  = cen_q;
  assign sram_oen  = oen_q;
  assign sram_wen  = wen_q;
  assign sram_ubn  = ubn_q;
  assign sram_lbn  = lbn_q;
  assign sram_data = drive_q ? wdat_q : 16'hzzzz;

endmodule

// File: tb/tb_sram_ctrl.sv
// Scoreboard bench for sram_ctrl: random Wishbone traffic against an SRAM
// model, with a timing/data reference model and a pin-level protocol monitor.
module tb_sram_ctrl;

  localparam int unsigned WRD = 2;
  localparam int unsigned WWR = 2;

  typedef struct {
    bit          is_rd;
    logic [15:0] data;
    int unsigned ack_edge;
  } sb_t;

  logic        clk_50mhz = 1'b0;
  logic        i_reset;
  logic [15:0] i_wb_addr, i_wb_dat;
  logic [1:0]  i_wb_sel;
  logic        i_wb_we, i_wb_cyc, i_wb_stb;
  logic [15:0] o_wb_dat;
  logic        o_wb_ack;
  logic [15:0] sram_addr;
  wire  [15:0] sram_data;
  logic        sram_cen, sram_oen, sram_wen, sram_ubn, sram_lbn;

  // Second instance with minimum wait states.
  logic [15:0] addr1, dat1;
  logic [1:0]  sel1;
  logic        we1, cyc1, stb1;
  logic [15:0] o_dat1;
  logic        ack1;
  logic [15:0] sram_addr1;
  wire  [15:0] sram_data1;
  logic        cen1, oen1, wen1, ubn1, lbn1;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned edge_n = 0;
  int unsigned next_free = 0;
  bit          tb_init = 1'b1;
  sb_t         sb_q[$];
  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [15:0] mem1;

  sram_ctrl #(.WAIT_RD(WRD), .WAIT_WR(WWR)) u_dut (
    .clk_50mhz(clk_50mhz), .i_reset(i_reset),
    .i_wb_addr(i_wb_addr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_cen(sram_cen), .sram_oen(sram_oen), .sram_wen(sram_wen),
    .sram_ubn(sram_ubn), .sram_lbn(sram_lbn)
  );

  sram_ctrl #(.WAIT_RD(1), .WAIT_WR(1)) u_dut1 (
    .clk_50mhz(clk_50mhz), .i_reset(i_reset),
    .i_wb_addr(addr1), .i_wb_dat(dat1), .i_wb_sel(sel1),
    .i_wb_we(we1), .i_wb_cyc(cyc1), .i_wb_stb(stb1),
    .o_wb_dat(o_dat1), .o_wb_ack(ack1),
    .sram_addr(sram_addr1), .sram_data(sram_data1),
    .sram_cen(cen1), .sram_oen(oen1), .sram_wen(wen1),
    .sram_ubn(ubn1), .sram_lbn(lbn1)
  );

  initial forever #10 clk_50mhz = ~clk_50mhz;
  initial forever begin
    @(posedge clk_50mhz);
    edge_n++;
  end

  function automatic logic [15:0] init_val(input int i);
    if (i == 'h123) return 16'hBEEF;
    return 16'(i * 37 + 'h1357) ^ 16'hA5C3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Asynchronous SRAM models: drive while selected and output-enabled, write
  // the enabled lanes every cycle the write strobe is low.
  assign sram_data  = (!sram_cen && !sram_oen) ? mem[sram_addr[9:0]] : 16'hzzzz;
  assign sram_data1 = (!cen1 && !oen1) ? mem1 : 16'hzzzz;

  initial forever begin
    @(negedge clk_50mhz);
    if (tb_init) begin
      for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
      mem1 = 16'h0000;
    end else begin
      if (!sram_cen && !sram_wen) begin
        if (!sram_lbn) mem[sram_addr[9:0]][7:0]  = sram_data[7:0];
        if (!sram_ubn) mem[sram_addr[9:0]][15:8] = sram_data[15:8];
      end
      if (!cen1 && !wen1) begin
        if (!lbn1) mem1[7:0]  = sram_data1[7:0];
        if (!ubn1) mem1[15:8] = sram_data1[15:8];
      end
    end
  end

  // Scoreboard monitor: each acknowledge retires the oldest expectation.
  initial forever begin
    sb_t e;
    @(negedge clk_50mhz);
    if (o_wb_ack) begin
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("ack_edge", edge_n, e.ack_edge);
        if (e.is_rd) check("rd_data", o_wb_dat, e.data);
      end
    end
  end

  // Pin monitor: every chip-enable window must have the shape of one access.
  initial begin
    int unsigned cen_run = 0, oen_run = 0, wen_run = 0;
    bit run_abort = 1'b0, first_wen_hi = 1'b0, last_wen_hi = 1'b0, pins_moved = 1'b0;
    logic [17:0] run_pins = '0;
    forever begin
      @(negedge clk_50mhz);
      if (i_reset) run_abort = 1'b1;
      if (!sram_oen) begin
        check("oen_needs_cen", sram_cen, 1'b0);
        check("rd_wen_high", sram_wen, 1'b1);
        check("rd_lanes", {sram_ubn, sram_lbn}, 2'b00);
      end
      if (!sram_cen) begin
        if (cen_run == 0) begin
          run_pins     = {sram_addr, sram_ubn, sram_lbn};
          first_wen_hi = sram_wen;
          pins_moved   = 1'b0;
        end else if ({sram_addr, sram_ubn, sram_lbn} != run_pins) begin
          pins_moved = 1'b1;
        end
        cen_run++;
        if (!sram_oen) oen_run++;
        if (!sram_wen) wen_run++;
        last_wen_hi = sram_wen;
      end else begin
        if (cen_run != 0 && !run_abort) begin
          if (oen_run != 0) begin
            check("rd_cen_width", cen_run, WRD);
            check("rd_oen_width", oen_run, WRD);
          end else begin
            check("wr_cen_width", cen_run, WWR + 2);
            check("wr_wen_width", wen_run, WWR);
            check("wr_setup_hold", {first_wen_hi, last_wen_hi}, 2'b11);
          end
          check("pins_stable", pins_moved, 1'b0);
        end
        cen_run = 0;
        oen_run = 0;
        wen_run = 0;
        run_abort = 1'b0;
      end
    end
  end

  // Present a request (called just after a falling edge) and predict its
  // acceptance edge, acknowledge edge and data from the access rules.
  task automatic issue(input bit we, input logic [15:0] addr, input logic [15:0] dat,
                       input logic [1:0] sel, input bit expect_ack);
    sb_t e;
    int unsigned acc;
    i_wb_we = we; i_wb_addr = addr; i_wb_dat = dat; i_wb_sel = sel;
    i_wb_cyc = 1'b1; i_wb_stb = 1'b1;
    acc = (edge_n + 1 > next_free) ? edge_n + 1 : next_free;
    e.is_rd = !we;
    e.data  = ref_mem[addr[9:0]];
    if (we) begin
      if (sel[1]) ref_mem[addr[9:0]][15:8] = dat[15:8];
      if (sel[0]) ref_mem[addr[9:0]][7:0]  = dat[7:0];
      e.ack_edge = acc + WWR + 1;
      next_free  = acc + WWR + 3;
    end else begin
      e.ack_edge = acc + WRD;
      next_free  = acc + WRD + 2;
    end
    if (expect_ack) sb_q.push_back(e);
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_50mhz);
      if (o_wb_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    #1;
  endtask

  task automatic drop_req();
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
  endtask

  task automatic wait_pin(input bit want_wen);
    bit got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_50mhz);
      if ((want_wen ? sram_wen : sram_oen) == 1'b0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("strobe_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] a;
    int unsigned a1, wen_w;
    bit got;

    i_reset = 1'b1;
    i_wb_addr = '0; i_wb_dat = '0; i_wb_sel = '0; i_wb_we = 1'b0;
    i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
    addr1 = '0; dat1 = '0; sel1 = '0; we1 = 1'b0; cyc1 = 1'b0; stb1 = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    repeat (3) @(negedge clk_50mhz);
    check("reset_ctrl", {sram_cen, sram_oen, sram_wen, sram_ubn, sram_lbn}, 5'b11111);
    check("reset_ack", o_wb_ack, 1'b0);
    check("reset_dat", o_wb_dat, 16'h0000);
    check("reset_addr", sram_addr, 16'h0000);
    #1;
    i_reset = 1'b0;
    tb_init = 1'b0;

    // Directed read of the preloaded word.
    issue(1'b0, 16'h0123, 16'h0000, 2'b11, 1'b1);
    wait_ack();
    drop_req();
    @(negedge clk_50mhz); #1;

    // Directed lower-byte write.
    issue(1'b1, 16'h0040, 16'hA55A, 2'b01, 1'b1);
    wait_pin(1'b1);
    check("wr_lanes", {sram_ubn, sram_lbn}, 2'b10);
    check("wr_addr", sram_addr, 16'h0040);
    wait_ack();
    drop_req();
    @(negedge clk_50mhz); #1;
    check("wr_low_byte", mem[10'h040][7:0], 8'h5A);
    check("wr_word", mem[10'h040], ref_mem[10'h040]);

    // Write then read of the same word with the request held throughout.
    a = 16'($urandom);
    issue(1'b1, a, 16'($urandom), 2'b11, 1'b1);
    wait_ack();
    issue(1'b0, a, 16'h0000, 2'b11, 1'b1);
    wait_ack();
    drop_req();

    // Random traffic, mixing held requests and idle gaps.
    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
            2'($urandom_range(0, 3)), 1'b1);
      wait_ack();
      if ($urandom_range(0, 1) == 0) begin
        drop_req();
        repeat ($urandom_range(1, 3)) @(negedge clk_50mhz);
        #1;
      end
    end
    drop_req();
    @(negedge clk_50mhz); #1;

    // Reset while the write strobe is low; the request stays up across it.
    a = 16'h0200 | 16'($urandom_range(0, 255));
    issue(1'b1, a, 16'($urandom), 2'b11, 1'b0);
    wait_pin(1'b1);
    #1;
    i_reset = 1'b1;
    @(negedge clk_50mhz);
    check("rst_mid_ctrl", {sram_cen, sram_oen, sram_wen, sram_ubn, sram_lbn}, 5'b11111);
    check("rst_mid_ack", o_wb_ack, 1'b0);
    check("rst_mid_dat", o_wb_dat, 16'h0000);
    check("rst_mid_addr", sram_addr, 16'h0000);
    #1;
    i_reset = 1'b0;
    drop_req();
    next_free = 0;
    @(negedge clk_50mhz); #1;
    issue(1'b0, a, 16'h0000, 2'b11, 1'b1);
    wait_ack();
    drop_req();
    @(negedge clk_50mhz); #1;

    // Master abandons a read mid-cycle: no acknowledge, data still captured.
    a = 16'($urandom);
    issue(1'b0, a, 16'h0000, 2'b11, 1'b0);
    wait_pin(1'b0);
    #1;
    drop_req();
    for (int k = 0; k < WRD + 2; k++) begin
      @(negedge clk_50mhz);
      check("abort_no_ack", o_wb_ack, 1'b0);
    end
    check("abort_dat", o_wb_dat, ref_mem[a[9:0]]);
    #1;

    // Minimum wait states: write ack 3 cycles after acceptance, read ack 2.
    addr1 = 16'h0005; dat1 = 16'hC3A5; sel1 = 2'b11; we1 = 1'b1;
    cyc1 = 1'b1; stb1 = 1'b1;
    a1 = edge_n + 1;
    wen_w = 0;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_50mhz);
      if (!wen1) wen_w++;
      if (ack1) begin
        got = 1'b1;
        check("d1_wr_latency", edge_n - a1 + 1, 32'd3);
        break;
      end
    end
    check("d1_wr_ack_seen", got, 1'b1);
    check("d1_wen_width", wen_w, 32'd1);
    #1;
    cyc1 = 1'b0; stb1 = 1'b0;
    @(negedge clk_50mhz); #1;
    we1 = 1'b0; cyc1 = 1'b1; stb1 = 1'b1;
    a1 = edge_n + 1;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_50mhz);
      if (ack1) begin
        got = 1'b1;
        check("d1_rd_latency", edge_n - a1 + 1, 32'd2);
        check("d1_rd_data", o_dat1, 16'hC3A5);
        break;
      end
    end
    check("d1_rd_ack_seen", got, 1'b1);
    #1;
    cyc1 = 1'b0; stb1 = 1'b0;

    repeat (4) @(negedge clk_50mhz);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Bus slave between the d16 CPU Wishbone-style port and the external asynchronous 16-bit SRAM. It replaces the direct combinational wiring of CPU strobes to SRAM pins. Each access becomes a registered, multi-cycle SRAM cycle with programmable wait states, clean write setup and hold, data-bus turnaround and a one-cycle acknowledge. It sits directly downstream of the CPU and the address decode, and upstream of the SRAM pins.

## Interface
- WAIT_RD, default 2: cycles `sram_oen`/`sram_cen` are held low before read data is sampled; legal range 1..15.
- WAIT_WR, default 2: width of the `sram_wen` low pulse in cycles; legal range 1..15.
- clk_50mhz  in  1  system clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_wb_addr  in  16  word address.
- i_wb_dat  in  16  write data.
- i_wb_sel  in  2  byte lane enables; [1] selects the upper byte, [0] the lower byte.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_cyc  in  1  bus cycle active.
- i_wb_stb  in  1  request strobe.
- o_wb_dat  out  16  registered read data.
- o_wb_ack  out  1  single-cycle transfer acknowledge.
- sram_addr  out  16  registered SRAM address.
- sram_data  inout  16  SRAM data bus.
- sram_cen, sram_oen, sram_wen, sram_ubn, sram_lbn  out  1 each  active-low SRAM controls, all registered.

## Operation
- States: IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD. A 4-bit wait counter serves RD and WR_PULSE.
- IDLE: a request is accepted when `i_wb_cyc & i_wb_stb` is high at a clock edge.
  - On acceptance, latch the address, write data and `we`.
  - `sram_ubn`/`sram_lbn` take `~i_wb_sel` for writes and are forced 0 for reads.
  - Load the counter with WAIT_RD or WAIT_WR.
- Read path:
  - Move to RD. Hold `sram_cen` = 0 and `sram_oen` = 0; `sram_wen` stays 1.
  - Decrement the counter each cycle. On the edge where it reaches 0, capture `sram_data` into `o_wb_dat`, set `o_wb_ack`, and go to RD_DONE.
  - RD_DONE: cen/oen high, ack high for this cycle, then IDLE.
- Write path:
  - WR_SETUP (1 cycle): cen = 0, wen = 1, data driven.
  - WR_PULSE (WAIT_WR cycles): wen = 0.
  - WR_HOLD (1 cycle): wen = 1, cen = 0, data still driven, ack high; then IDLE.
- `sram_data` is driven only in WR_SETUP, WR_PULSE and WR_HOLD, from a registered enable. It is hi-Z in all other states. `sram_oen` is never low while the bus is driven.
- `o_wb_dat` holds its last captured value until the next read completes.
- No request is accepted in any state except IDLE. Back-to-back requests are therefore always separated by at least one cycle with cen high.
- `i_wb_cyc` dropped mid-transaction: the SRAM cycle still completes with full timing, no early termination of wen, and `o_wb_ack` is suppressed, i.e. gated with the current `i_wb_cyc`.
- `i_wb_addr`, `i_wb_dat`, `i_wb_sel` and `i_wb_we` are ignored after acceptance.

## Timing
- Request high before edge E0 is accepted at E0. The SRAM pins change after E0.
- Read: ack is high in the cycle following edge E0+WAIT_RD. Latency is WAIT_RD+1 cycles from acceptance to ack; the next acceptance is possible at E0+WAIT_RD+2.
- Write: wen falls after E1, rises after E1+WAIT_WR, and ack is high in that same hold cycle. Latency is WAIT_WR+2 cycles; the bus is released after E0+WAIT_WR+2.
- Address, ub/lb and write data are stable from one cycle before wen falls until one cycle after it rises.
- Reset, including mid-transaction: at the next edge go to IDLE with:
  - `sram_cen`, `sram_oen`, `sram_wen`, `sram_ubn`, `sram_lbn` = 1
  - `sram_data` hi-Z
  - `o_wb_ack` = 0, `o_wb_dat` = 16'h0000, `sram_addr` = 16'h0000
  - reset overrides any acceptance on that edge.

## Test plan
- Read with WAIT_RD=2: SRAM model returns 16'hBEEF at 16'h0123 → oen low for exactly 2 cycles, ack one cycle 3 cycles after acceptance, `o_wb_dat` = 16'hBEEF.
- Write with WAIT_WR=2, sel=2'b01, 16'hA55A to 16'h0040 → setup 1, wen low 2, hold 1 cycles; ubn = 1, lbn = 0; SRAM lower byte = 16'h5A; ack in the hold cycle; bus hi-Z afterward.
- Write immediately followed by a read of the same address, with the request held continuously → no cycle where oen = 0 and the bus is driven; read returns the written data; at least one cen-high gap.
- Reset asserted during WR_PULSE → next cycle wen = 1, cen = 1, bus hi-Z, ack = 0, state IDLE; a following read works normally.
- Read with `i_wb_cyc` dropped during RD → SRAM cycle completes, `o_wb_ack` stays 0, `o_wb_dat` is updated.
- WAIT_RD=1, WAIT_WR=1 → read ack latency 2 cycles, write ack latency 3 cycles, wen pulse exactly 1 cycle.
